mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_accumulator_product_stage.sv | 26 ++
 rtl/mac_accumulator.sv | 119 +++++++++++
 tb/tb_mac_accumulator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate frame engine.
package mac_pkg;

    localparam int unsigned ACC_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned OPND_W    = 2;
    localparam int unsigned PROD_W    = 4;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [PROD_W-1:0] mul2x2(input logic [OPND_W-1:0] a,
                                                 input logic [OPND_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

endpackage

// File: rtl/mac_accumulator_product_stage.sv
// 2x2 unsigned multiply with a registered product and valid flag.
module product_stage
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] prod,
    output logic              prod_valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= accept;
            if (accept) begin
                prod <= mul2x2(a, b);
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Frame-based multiply-accumulate: sums in_a*in_b per frame with saturation,
// presents the result with a valid/ready handshake.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q;
    state_t             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [PROD_W-1:0]  prod;
    logic               prod_valid;
    logic               accept;
    logic               handshake;
    logic [ACC_W:0]     acc_sum;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    product_stage u_product_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (accept),
        .a          (in_a),
        .b          (in_b),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake strobes; both strobes are forced low during reset.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
        if (!rst_n) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // One extra bit catches the carry that signals saturation.
    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(prod);

    // Accumulator, beat counter and overflow flag; cleared when the result is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (handshake) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (prod_valid) begin
                if (acc_sum[ACC_W]) begin
                    acc_q <= '1;
                    ovf_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum[ACC_W-1:0];
                end
            end
            if (accept && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_sum   = rst_n ? acc_q : '0;
    assign out_count = rst_n ? cnt_q : '0;
    assign out_ovf   = rst_n && ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a frame-level reference model.
module tb_mac_accumulator;

    localparam int unsigned ACC_W   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int          ACC_MAX = (1 << ACC_W) - 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [1:0]       in_a      = 2'd0;
    logic [1:0]       in_b      = 2'd0;
    logic             in_last   = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model: running sum/count, one drain cycle, then a pending result.
    int m_sum   = 0;
    int m_cnt   = 0;
    bit m_ovf   = 1'b0;
    bit m_valid = 1'b0;
    int m_delay = 0;
    bit chk_en  = 1'b0;

    mac_accumulator #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int p;
        if (!rst_n) begin
            m_sum = 0; m_cnt = 0; m_ovf = 1'b0; m_valid = 1'b0; m_delay = 0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_sum = 0; m_cnt = 0; m_ovf = 1'b0; m_valid = 1'b0;
            end
        end else if (m_delay > 0) begin
            m_delay--;
            if (m_delay == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            p = int'(in_a) * int'(in_b);
            if (m_sum + p > ACC_MAX) begin
                m_sum = ACC_MAX;
                m_ovf = 1'b1;
            end else begin
                m_sum += p;
            end
            if (m_cnt < CNT_MAX) m_cnt++;
            if (in_last) m_delay = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(rst_n && !m_valid && m_delay == 0));
            chk("out_valid", 32'(out_valid), 32'(rst_n && m_valid));
            if (!rst_n) begin
                chk("rst out_sum", 32'(out_sum), 32'd0);
                chk("rst out_count", 32'(out_count), 32'd0);
                chk("rst out_ovf", 32'(out_ovf), 32'd0);
            end else if (m_valid) begin
                chk("out_sum", 32'(out_sum), 32'(m_sum));
                chk("out_count", 32'(out_count), 32'(m_cnt));
                chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
            end
        end
    end

    task automatic send(input int a, input int b, input bit last);
        bit took = 1'b0;
        in_valid = 1'b1;
        in_a     = 2'(a);
        in_b     = 2'(b);
        in_last  = last;
        for (int i = 0; i < 50 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send timeout: got in_ready 0 expected 1 at %0t", $time);
        end
    endtask

    task automatic wait_frame(input string name, input int sum, input int cnt, input bit ovf);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got out_valid 0 expected 1 at %0t", name, $time);
        end else begin
            chk({name, " sum"}, 32'(out_sum), 32'(sum));
            chk({name, " count"}, 32'(out_count), 32'(cnt));
            chk({name, " ovf"}, 32'(out_ovf), 32'(ovf));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single beat: one drain cycle, then the result.
        send(3, 3, 1'b1);
        @(negedge clk);
        chk("latency drain out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency hold out_valid", 32'(out_valid), 32'd1);
        chk("single sum", 32'(out_sum), 32'd9);
        chk("single count", 32'(out_count), 32'd1);
        chk("single ovf", 32'(out_ovf), 32'd0);
        @(posedge clk);
        #1;

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                send(a, b, (a == 3) && (b == 3));
        wait_frame("sweep", 36, 16, 1'b0);

        for (int i = 1; i <= 29; i++) send(3, 3, i == 29);
        wait_frame("saturate", 255, 29, 1'b1);
        send(1, 2, 1'b1);
        wait_frame("after saturate", 2, 1, 1'b0);

        send(1, 3, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        send(2, 1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        send(3, 2, 1'b1);
        wait_frame("gaps", 11, 3, 1'b0);

        // Back-pressure: result held, offered beats ignored.
        out_ready = 1'b0;
        send(2, 3, 1'b0);
        send(1, 1, 1'b1);
        wait_frame("backpressure", 7, 2, 1'b0);
        in_valid = 1'b1; in_a = 2'd3; in_b = 2'd3; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold sum", 32'(out_sum), 32'd7);
            chk("hold count", 32'(out_count), 32'd2);
            chk("hold in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ready after handshake", 32'(in_ready), 32'd1);
        chk("valid after handshake", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(0, 2, 1'b1);
        wait_frame("post hold", 0, 1, 1'b0);

        // Reset mid-frame discards the partial sum.
        for (int i = 0; i < 3; i++) send(2, 2, 1'b0);
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        send(1, 1, 1'b1);
        wait_frame("after reset", 1, 1, 1'b0);

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
